instr_fetch_responder: RTL and testbench

//  Instruction-memory responder at the far end of the fetch interface driven by the program counter.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_rsp_fifo2.sv | 51 +++++
 rtl/instr_fetch_responder.sv | 108 ++++++++++
 tb/tb_instr_fetch_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch responder: error codes, the NOP
// returned on faulting fetches, and the response record.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OK       = 2'b00,
    FETCH_MISALIGN = 2'b01,
    FETCH_RANGE    = 2'b10
  } fetch_err_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          FETCH_ADDR_W = 32;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] addr;
    fetch_err_e              err;
  } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo2.sv
// Two-entry response FIFO with push/pop/clear. The record type is a
// parameter so the top can carry a response with any address width.
module fetch_rsp_fifo2
  import fetch_pkg::*;
#(
  parameter type T = fetch_rsp_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           pop_data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  T           slot [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) slot[wr_ptr] <= push_data;
  end

  assign pop_data = slot[rd_ptr];
  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign count    = cnt;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: registered ROM read per accepted fetch,
// at most two responses outstanding (read stage + FIFO), flushable.
module instr_fetch_responder
  import fetch_pkg::*;
#(
  parameter int    n           = 32,
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [n-1:0] req_addr,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_instr,
  output logic [n-1:0] rsp_addr,
  output logic [1:0]   rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic [31:0]  instr;
    logic [n-1:0] addr;
    fetch_err_e   err;
  } rsp_t;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  // Misalignment outranks out-of-range when both apply.
  function automatic fetch_err_e classify(input logic [n-1:0] a);
    if (a[1:0] != 2'b00)         return FETCH_MISALIGN;
    if (a[n-1:IDX_W+2] != '0)    return FETCH_RANGE;
    return FETCH_OK;
  endfunction

  logic             accept;
  logic             pop;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_cnt;
  logic [1:0]       occ;
  logic [IDX_W-1:0] rd_idx;
  fetch_err_e       req_err;
  rsp_t             fifo_head;
  rsp_t             head;
  logic             rs_vld;
  rsp_t             rs_q;

  assign rd_idx  = req_addr[IDX_W+1:2];
  assign req_err = classify(req_addr);

  // Ready looks only at registered occupancy, so a pop frees a slot one cycle later.
  assign occ       = fifo_cnt + {1'b0, rs_vld};
  assign req_ready = !reset && !flush && !fifo_full && (occ < 2'd2);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = rs_vld || !fifo_empty;
  assign head      = fifo_empty ? rs_q : fifo_head;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign fifo_pop  = pop && !fifo_empty;
  // The read-stage entry parks in the FIFO unless it is consumed directly.
  assign fifo_push = rs_vld && !(pop && fifo_empty) && !flush;

  // ---- read stage: registered memory access ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_vld <= 1'b0;
      rs_q   <= '0;
    end else begin
      rs_vld <= accept;
      if (accept) begin
        rs_q.addr <= req_addr;
        rs_q.err  <= req_err;
        if (req_err == FETCH_OK) rs_q.instr <= mem[rd_idx];
        else                     rs_q.instr <= NOP_INSTR;
      end
    end
  end

  // ---- response buffer ----
  fetch_rsp_fifo2 #(.T(rsp_t)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (rs_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign rsp_instr = head.instr;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_responder;
  import fetch_pkg::*;

  localparam int N     = 32;
  localparam int DEPTH = 256;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         flush     = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_addr  = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [31:0]  rsp_instr;
  logic [N-1:0] rsp_addr;
  logic [1:0]   rsp_err;

  instr_fetch_responder #(.n(N), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] img [DEPTH];
  logic [31:0] b2b_exp [4] = '{32'h1000_0000, 32'h1001_0003, 32'h1002_0006, 32'h1003_0009};

  typedef struct {
    logic [31:0]  instr;
    logic [N-1:0] addr;
    logic [1:0]   err;
  } exp_t;

  exp_t q[$];
  bit   m_pop;
  bit   m_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input logic [N-1:0] a);
    exp_t e;
    e.addr = a;
    if (a[1:0] != 2'b00) begin
      e.err = 2'b01; e.instr = 32'h0000_0013;
    end else if (a >= DEPTH * 4) begin
      e.err = 2'b10; e.instr = 32'h0000_0013;
    end else begin
      e.err = 2'b00; e.instr = img[a / 4];
    end
    return e;
  endfunction

  // Reference: an in-order queue of at most two visible responses.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      q.delete();
    end else begin
      m_pop = (q.size() > 0) && rsp_ready;
      m_acc = req_valid && (q.size() < 2);
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(expect_of(req_addr));
    end
  end

  always @(negedge clk) begin
    check("req_ready", {63'd0, req_ready}, {63'd0, (!reset && !flush && q.size() < 2)});
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, (q.size() > 0)});
    if (q.size() > 0 && rsp_valid) begin
      check("rsp_instr", {32'd0, rsp_instr}, {32'd0, q[0].instr});
      check("rsp_addr",  {32'd0, rsp_addr},  {32'd0, q[0].addr});
      check("rsp_err",   {62'd0, rsp_err},   {62'd0, q[0].err});
    end
    if (q.size() > 2) check("occupancy", 64'(q.size()), 64'd2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int cycles;
  int r;

  initial begin
    for (int i = 0; i < DEPTH; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    #1;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = img[i];
    step(); step();
    check("reset_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_instr", {32'd0, rsp_instr}, 64'd0);
    check("reset_addr",  {32'd0, rsp_addr},  64'd0);
    check("reset_err",   {62'd0, rsp_err},   64'd0);
    check("reset_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b0;
    step();
    check("post_reset_ready", {63'd0, req_ready}, 64'd1);

    // back-to-back fetches with the consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
      check("b2b_valid", {63'd0, rsp_valid}, 64'd1);
      check("b2b_instr", {32'd0, rsp_instr}, {32'd0, b2b_exp[i]});
      check("b2b_err",   {62'd0, rsp_err},   64'd0);
    end
    req_valid = 1'b0;
    step();

    // backpressure: fill, hold, then drain
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h4; step();
    check("full_ready", {63'd0, req_ready}, 64'd0);
    check("hold_instr", {32'd0, rsp_instr}, 64'h1000_0000);
    req_addr = 32'h8; step();
    check("hold_instr2", {32'd0, rsp_instr}, 64'h1000_0000);
    check("hold_addr",   {32'd0, rsp_addr},  64'h0);
    req_valid = 1'b0; rsp_ready = 1'b1; step();
    check("drain_ready", {63'd0, req_ready}, 64'd1);
    check("drain_addr",  {32'd0, rsp_addr},  64'h4);
    check("drain_instr", {32'd0, rsp_instr}, 64'h1001_0003);
    step();
    check("drain_empty", {63'd0, rsp_valid}, 64'd0);

    // error responses
    req_valid = 1'b1; req_addr = 32'h6; step();
    check("misalign_err",   {62'd0, rsp_err},   64'd1);
    check("misalign_instr", {32'd0, rsp_instr}, 64'h13);
    req_addr = 32'h400; step();
    check("range_err",   {62'd0, rsp_err},   64'd2);
    check("range_instr", {32'd0, rsp_instr}, 64'h13);
    check("range_addr",  {32'd0, rsp_addr},  64'h400);
    req_valid = 1'b0; step();

    // flush with two buffered and a request presented
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h20; step();
    req_addr = 32'h24; step();
    flush = 1'b1; req_addr = 32'h28; step();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_valid", {63'd0, rsp_valid}, 64'd0);
    req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1; step();
    check("after_flush_instr", {32'd0, rsp_instr}, 64'h1004_000C);
    check("after_flush_addr",  {32'd0, rsp_addr},  64'h10);
    req_valid = 1'b0; step();
    check("flush_dropped", {63'd0, rsp_valid}, 64'd0);

    // reset while two entries are outstanding
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h4; step();
    reset = 1'b1; #1;
    check("midrst_valid", {63'd0, rsp_valid}, 64'd0);
    check("midrst_instr", {32'd0, rsp_instr}, 64'd0);
    check("midrst_addr",  {32'd0, rsp_addr},  64'd0);
    check("midrst_err",   {62'd0, rsp_err},   64'd0);
    req_valid = 1'b0; step();
    reset = 1'b0; step();
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1; step();
    check("post_midrst_instr", {32'd0, rsp_instr}, 64'h1000_0000);
    req_valid = 1'b0; step();
    check("post_midrst_empty", {63'd0, rsp_valid}, 64'd0);

    // random valid/ready traffic
    sent = 0; cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)      req_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + 1);
      else if (r == 1) req_addr = 32'h400 + 32'($urandom_range(0, 255) * 4);
      else             req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      #1;
      if (req_valid && req_ready) sent++;
      @(posedge clk); #1;
      cycles++;
    end
    if (sent < 1000) check("random_budget", 64'(sent), 64'd1000);
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    step(); step(); step();
    check("final_empty", {63'd0, rsp_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
